// File: rtl/mips_ascii_pkg.sv
// ============================================================================
//  Module   : mips_ascii_pkg
//  Brief    : Shared types, ASCII constants and register numbers for the
//             MIPS ABI register-name parser. Optional REG_NUMERIC_ALIAS_EN
//             adds the S_THIRD state for two-digit "$nn" aliases.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ascii_pkg;

    typedef logic [4:0] regaddr_t;

`ifdef REG_NUMERIC_ALIAS_EN
    typedef enum logic [2:0] {
        S_FIRST  = 3'd0,
        S_SECOND = 3'd1,
        S_DRAIN  = 3'd2,
        S_OUT    = 3'd3,
        S_THIRD  = 3'd4
    } parse_state_t;
`else
    typedef enum logic [2:0] {
        S_FIRST  = 3'd0,
        S_SECOND = 3'd1,
        S_DRAIN  = 3'd2,
        S_OUT    = 3'd3
    } parse_state_t;
`endif

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_1      = 8'h31;
    localparam logic [7:0] CH_3      = 8'h33;
    localparam logic [7:0] CH_7      = 8'h37;
    localparam logic [7:0] CH_8      = 8'h38;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_A      = 8'h61;
    localparam logic [7:0] CH_F      = 8'h66;
    localparam logic [7:0] CH_G      = 8'h67;
    localparam logic [7:0] CH_K      = 8'h6B;
    localparam logic [7:0] CH_P      = 8'h70;
    localparam logic [7:0] CH_R      = 8'h72;
    localparam logic [7:0] CH_S      = 8'h73;
    localparam logic [7:0] CH_T      = 8'h74;
    localparam logic [7:0] CH_V      = 8'h76;

    localparam regaddr_t REG_ZERO = 5'd0;
    localparam regaddr_t REG_AT   = 5'd1;
    localparam regaddr_t REG_V0   = 5'd2;
    localparam regaddr_t REG_A0   = 5'd4;
    localparam regaddr_t REG_T0   = 5'd8;
    localparam regaddr_t REG_S0   = 5'd16;
    localparam regaddr_t REG_T8   = 5'd24;
    localparam regaddr_t REG_K0   = 5'd26;
    localparam regaddr_t REG_GP   = 5'd28;
    localparam regaddr_t REG_SP   = 5'd29;
    localparam regaddr_t REG_FP   = 5'd30;
    localparam regaddr_t REG_RA   = 5'd31;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

    function automatic logic is_prefix(input logic [7:0] ch);
        logic r;
        case (ch)
            CH_DOLLAR, CH_A, CH_V, CH_T, CH_S, CH_K, CH_G, CH_F, CH_R: r = 1'b1;
            default:                                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_suffix_decode.sv
// ============================================================================
//  Module   : reg_suffix_decode
//  Brief    : Combinational lookup of a {prefix, second char} pair to a
//             canonical MIPS ABI register number.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_suffix_decode
    import mips_ascii_pkg::*;
(
    input  logic [7:0] prefix,
    input  logic [7:0] ch,
    output logic       hit,
    output regaddr_t   regaddr
);

    always_comb begin
        hit     = 1'b0;
        regaddr = REG_ZERO;
        case (prefix)
            CH_DOLLAR: begin
                if (ch == CH_0) begin
                    hit     = 1'b1;
                    regaddr = REG_ZERO;
                end
            end
            CH_A: begin
                if (ch == CH_T) begin
                    hit     = 1'b1;
                    regaddr = REG_AT;
                end else if (ch >= CH_0 && ch <= CH_3) begin
                    hit     = 1'b1;
                    regaddr = REG_A0 + {3'b000, ch[1:0]};
                end
            end
            CH_V: begin
                if (ch == CH_0 || ch == CH_1) begin
                    hit     = 1'b1;
                    regaddr = REG_V0 + {4'b0000, ch[0]};
                end
            end
            // t0-t7 and t8-t9 are not contiguous in the register file
            CH_T: begin
                if (ch >= CH_0 && ch <= CH_7) begin
                    hit     = 1'b1;
                    regaddr = REG_T0 + {2'b00, ch[2:0]};
                end else if (ch == CH_8 || ch == CH_9) begin
                    hit     = 1'b1;
                    regaddr = REG_T8 + {4'b0000, ch[0]};
                end
            end
            CH_S: begin
                if (ch >= CH_0 && ch <= CH_7) begin
                    hit     = 1'b1;
                    regaddr = REG_S0 + {2'b00, ch[2:0]};
                end else if (ch == CH_P) begin
                    hit     = 1'b1;
                    regaddr = REG_SP;
                end
            end
            CH_K: begin
                if (ch == CH_0 || ch == CH_1) begin
                    hit     = 1'b1;
                    regaddr = REG_K0 + {4'b0000, ch[0]};
                end
            end
            CH_G: begin
                if (ch == CH_P) begin
                    hit     = 1'b1;
                    regaddr = REG_GP;
                end
            end
            CH_F: begin
                if (ch == CH_P) begin
                    hit     = 1'b1;
                    regaddr = REG_FP;
                end
            end
            CH_R: begin
                if (ch == CH_A) begin
                    hit     = 1'b1;
                    regaddr = REG_RA;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/reg_name_parser.sv
// ============================================================================
//  Module   : reg_name_parser
//  Brief    : Streams a lowercase MIPS ABI register name one char per
//             handshake and returns its number or an error per token.
//             Define REG_NUMERIC_ALIAS_EN to also accept "$0".."$31".
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_name_parser
    import mips_ascii_pkg::*;
#(
    parameter regaddr_t ERR_ADDR = 5'd0,
    parameter int       CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output regaddr_t         out_regaddr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    parse_state_t     r_state;
    parse_state_t     w_state_nxt;
    logic [7:0]       r_prefix;
    regaddr_t         r_regaddr;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_acc;
    logic             w_hit;
    regaddr_t         w_dec_addr;
    logic             w_load;
    logic             w_res_err;
    regaddr_t         w_res_addr;
    logic             w_prefix_load;
`ifdef REG_NUMERIC_ALIAS_EN
    logic [3:0]       r_digit;
    logic             w_digit_load;
    logic [6:0]       w_num;

    assign w_num = ({3'b000, r_digit} * 7'd10) + {3'b000, in_char[3:0]};
`endif

    assign in_ready    = (r_state != S_OUT);
    assign w_acc       = in_valid & in_ready;
    assign out_valid   = (r_state == S_OUT);
    assign out_regaddr = r_regaddr;
    assign out_err     = r_err;
    assign err_cnt     = r_err_cnt;

    reg_suffix_decode u_suffix_decode (
        .prefix  (r_prefix),
        .ch      (in_char),
        .hit     (w_hit),
        .regaddr (w_dec_addr)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_res_err     = 1'b0;
        w_res_addr    = REG_ZERO;
        w_prefix_load = 1'b0;
`ifdef REG_NUMERIC_ALIAS_EN
        w_digit_load  = 1'b0;
`endif
        case (r_state)
            S_FIRST: begin
                if (w_acc) begin
                    if (in_last) begin
                        w_load      = 1'b1;
                        w_res_err   = 1'b1;
                        w_state_nxt = S_OUT;
                    end else if (is_prefix(in_char)) begin
                        w_prefix_load = 1'b1;
                        w_state_nxt   = S_SECOND;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_SECOND: begin
                if (w_acc) begin
`ifdef REG_NUMERIC_ALIAS_EN
                    // "$1".."$9" and the first digit of "$10".."$31"; "$0" falls through to the table
                    if (r_prefix == CH_DOLLAR && is_digit(in_char) && in_char != CH_0) begin
                        if (in_last) begin
                            w_load      = 1'b1;
                            w_res_addr  = {1'b0, in_char[3:0]};
                            w_state_nxt = S_OUT;
                        end else begin
                            w_digit_load = 1'b1;
                            w_state_nxt  = S_THIRD;
                        end
                    end else
`endif
                    if (in_last) begin
                        w_load      = 1'b1;
                        w_res_err   = !w_hit;
                        w_res_addr  = w_dec_addr;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
`ifdef REG_NUMERIC_ALIAS_EN
            S_THIRD: begin
                if (w_acc) begin
                    if (in_last) begin
                        w_load      = 1'b1;
                        w_res_err   = !(is_digit(in_char) && (w_num <= 7'd31));
                        w_res_addr  = w_num[4:0];
                        w_state_nxt = S_OUT;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (w_acc && in_last) begin
                    w_load      = 1'b1;
                    w_res_err   = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_FIRST;
                end
            end
            default: w_state_nxt = S_FIRST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FIRST;
            r_prefix  <= 8'h00;
            r_regaddr <= REG_ZERO;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
`ifdef REG_NUMERIC_ALIAS_EN
            r_digit   <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_prefix_load) begin
                r_prefix <= in_char;
            end
`ifdef REG_NUMERIC_ALIAS_EN
            if (w_digit_load) begin
                r_digit <= in_char[3:0];
            end
`endif
            if (w_load) begin
                r_err     <= w_res_err;
                r_regaddr <= w_res_err ? ERR_ADDR : w_res_addr;
                if (w_res_err && !(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_name_parser.sv
// ============================================================================
//  Module   : tb_reg_name_parser
//  Brief    : Self-checking bench for reg_name_parser (directed token table
//             plus stall, idle-gap and mid-token reset sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_name_parser;
    import mips_ascii_pkg::*;

    localparam regaddr_t TB_ERR_ADDR = 5'd21;
    localparam int       TB_CNT_W    = 3;
    localparam int       CNT_MAX     = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_char;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    regaddr_t            out_regaddr;
    logic                out_err;
    logic [TB_CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    reg_name_parser #(
        .ERR_ADDR (TB_ERR_ADDR),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_regaddr (out_regaddr),
        .out_err     (out_err),
        .err_cnt     (err_cnt)
    );

    typedef struct {
        string      tok;
        logic       err;
        logic [4:0] addr;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string t, input logic e, input logic [4:0] a);
        vec_t v;
        v.tok  = t;
        v.err  = e;
        v.addr = a;
        vecs.push_back(v);
    endtask

    task automatic send_char(input logic [7:0] c, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_token(input string s, input int gap);
        for (int k = 0; k < s.len(); k++) begin
            send_char(s[k], (k == s.len() - 1));
            if (k != s.len() - 1) repeat (gap) step();
        end
    endtask

    // Called right after the last char's accepting edge: result must already be up.
    task automatic expect_result(input string name, input logic err, input logic [4:0] addr);
        if (err) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
        chk({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, " out_err"}, {31'd0, out_err}, {31'd0, err});
        chk({name, " out_regaddr"}, {27'd0, out_regaddr}, {27'd0, (err ? TB_ERR_ADDR : addr)});
        chk({name, " err_cnt"}, {29'd0, err_cnt}, exp_cnt);
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, " released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string canon[32] = '{"$0", "at", "v0", "v1", "a0", "a1", "a2", "a3",
                             "t0", "t1", "t2", "t3", "t4", "t5", "t6", "t7",
                             "s0", "s1", "s2", "s3", "s4", "s5", "s6", "s7",
                             "t8", "t9", "k0", "k1", "gp", "sp", "fp", "ra"};
        for (int i = 0; i < 32; i++) add(canon[i], 1'b0, i[4:0]);
        add("t9", 1'b0, 5'd25);
        add("k1", 1'b0, 5'd27);
        add("sp", 1'b0, 5'd29);
        add("ra", 1'b0, 5'd31);
        add("a4", 1'b1, 5'd0);
        add("spx", 1'b1, 5'd0);
        add("s", 1'b1, 5'd0);
        add("RA", 1'b1, 5'd0);
        add("zzzz", 1'b1, 5'd0);
        add("v2", 1'b1, 5'd0);
        add("gx", 1'b1, 5'd0);
        add("t8", 1'b0, 5'd24);
        add("$0", 1'b0, 5'd0);
        add("$32", 1'b1, 5'd0);
        add("$05", 1'b1, 5'd0);
        add("$x", 1'b1, 5'd0);
`ifdef REG_NUMERIC_ALIAS_EN
        add("$5", 1'b0, 5'd5);
        add("$7", 1'b0, 5'd7);
        add("$31", 1'b0, 5'd31);
        add("$10", 1'b0, 5'd10);
        add("$3x", 1'b1, 5'd0);
`else
        add("$5", 1'b1, 5'd0);
        add("$7", 1'b1, 5'd0);
        add("$31", 1'b1, 5'd0);
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_err", {31'd0, out_err}, 32'd0);
        chk("reset out_regaddr", {27'd0, out_regaddr}, 32'd0);
        chk("reset err_cnt", {29'd0, err_cnt}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            send_token(vecs[i].tok, 0);
            expect_result(vecs[i].tok, vecs[i].err, vecs[i].addr);
        end

        // idle cycles between chars must not disturb the token
        send_token("k0", 3);
        expect_result("k0 gap", 1'b0, 5'd26);

        // consumer stall: result held, input blocked while next char is offered
        send_token("gp", 0);
        in_valid = 1'b1;
        in_char  = "r";
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall out_regaddr", {27'd0, out_regaddr}, 32'd28);
            chk("stall out_err", {31'd0, out_err}, 32'd0);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall release in_ready", {31'd0, in_ready}, 32'd1);
        step();
        send_char("a", 1'b1);
        expect_result("ra after stall", 1'b0, 5'd31);

        // reset mid-token discards the partial 'v'
        send_char("v", 1'b0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        exp_cnt = 0;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst err_cnt", {29'd0, err_cnt}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        step();
        step();
        chk("midrst no stale", {31'd0, out_valid}, 32'd0);
        send_token("at", 0);
        expect_result("at after rst", 1'b0, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
